parity_8b_gen: RTL and testbench

//   Even-parity generator for an 8-bit data word: out = XOR of all 8 input bits.
//   out is 1 when in_ has an odd number of ones.

---
 rtl/parity_8b_gen.sv | 25 ++
 tb/tb_parity_8b_gen.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/parity_8b_gen.sv
// parity_8b_gen: parity bit of an 8-bit word, even by default or odd via ODD_PARITY.
// Define PARITY_REG_EN to take out from a flop with one cycle of latency.
module parity_8b_gen #(
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_,
  output logic       out
);
  logic par_d;
  always_comb par_d = (^in_) ^ ODD_PARITY;
`ifdef PARITY_REG_EN
  logic par_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) par_q <= 1'b0;
    else        par_q <= par_d;
  end
  assign out = par_q;
`else
  logic unused_ok;
  assign unused_ok = clk ^ reset;
  assign out = par_d;
`endif
endmodule

// File: tb/tb_parity_8b_gen.sv
// tb_parity_8b_gen: directed and random checks of parity_8b_gen against a bit-counting model.
module tb_parity_8b_gen;
  localparam bit ODD = 1'b0;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] in_ = 8'h00;
  logic out;
  int tests = 0;
  int fails = 0;

  parity_8b_gen #(.ODD_PARITY(ODD)) dut (.clk(clk), .reset(reset), .in_(in_), .out(out));

  always #5 clk = ~clk;

  function automatic logic model(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return ((n % 2) == 1) ^ ODD;
  endfunction

  task automatic check(input string tag, input logic o, input logic e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic apply(input logic [7:0] v);
    @(negedge clk);
    in_ = v;
    #1;
  endtask

  logic [15:0] nib = 16'h6996;
  logic [7:0] dv [4] = '{8'hFF, 8'hFE, 8'hA5, 8'h7F};
  logic       de [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] r;
  logic [7:0] prev;

  initial begin
`ifndef PARITY_REG_EN
    reset = 1'b0;
    apply(8'h00);
    check("reset_zero", out, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      apply(8'(i));
      check($sformatf("nibble_%0h", i), out, nib[i] ^ ODD);
    end
    for (int i = 0; i < 8; i++) begin
      apply(8'(1 << i));
      check($sformatf("walk_%0d", i), out, 1'b1 ^ ODD);
    end
    for (int i = 0; i < 4; i++) begin
      apply(dv[i]);
      check($sformatf("dense_%h", dv[i]), out, de[i] ^ ODD);
    end
    for (int i = 0; i < 20; i++) begin
      r = 8'($urandom);
      @(negedge clk);
      in_ = r;
      @(posedge clk);
      #4;
      check($sformatf("rand_%h", r), out, model(r));
    end
    apply(8'h01);
    for (int i = 0; i < 6; i++) begin
      reset = ~reset;
      #1;
      check($sformatf("rst_indep_%0d", i), out, 1'b1 ^ ODD);
      @(posedge clk);
      #1;
      check($sformatf("clk_indep_%0d", i), out, 1'b1 ^ ODD);
    end
    reset = 1'b1;
`else
    in_ = 8'h55;
    #2;
    reset = 1'b0;
    #1;
    check("async_clear", out, 1'b0);
    @(posedge clk);
    #1;
    check("held_in_reset", out, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    in_ = 8'h01;
    #1;
    check("before_first_edge", out, 1'b0);
    @(posedge clk);
    #1;
    check("first_capture_01", out, 1'b1 ^ ODD);
    @(negedge clk);
    in_ = 8'h03;
    #1;
    check("latency_hold", out, 1'b1 ^ ODD);
    @(posedge clk);
    #1;
    check("capture_03", out, 1'b0 ^ ODD);
    for (int i = 0; i < 16; i++) begin
      apply(8'(i));
      @(posedge clk);
      #1;
      check($sformatf("nibble_%0h", i), out, nib[i] ^ ODD);
    end
    for (int i = 0; i < 8; i++) begin
      apply(8'(1 << i));
      @(posedge clk);
      #1;
      check($sformatf("walk_%0d", i), out, 1'b1 ^ ODD);
    end
    for (int i = 0; i < 4; i++) begin
      apply(dv[i]);
      @(posedge clk);
      #1;
      check($sformatf("dense_%h", dv[i]), out, de[i] ^ ODD);
    end
    prev = in_;
    for (int i = 0; i < 20; i++) begin
      r = 8'($urandom);
      apply(r);
      check($sformatf("rand_hold_%0d", i), out, model(prev));
      @(posedge clk);
      #1;
      check($sformatf("rand_%h", r), out, model(r));
      prev = r;
    end
    apply(8'h01);
    @(posedge clk);
    #1;
    check("pre_midreset", out, 1'b1 ^ ODD);
    #2;
    reset = 1'b0;
    #1;
    check("midstream_clear", out, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("recapture", out, 1'b1 ^ ODD);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
